// File: rtl/toy_commit_mc.sv
// toy_commit_mc: retire-side architectural next-PC tracking and
// arbitration of debug/trap/xret/jump redirects toward fetch.
module toy_commit_mc #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH = 4,
    parameter bit RVC_EN = 1'b1,
    parameter logic [ADDR_WIDTH-1:0] RST_PC = 'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] DBG_PC = 'h800,
    parameter logic [ADDR_WIDTH-1:0] DBG_LOOP_PC = 'h808,
    parameter logic [ADDR_WIDTH-1:0] DBG_EXP_PC = 'h810
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ret_vld,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ret_pc,
    input  logic [NUM_CH-1:0]              ret_rvc,
    input  logic [NUM_CH-1:0]              ret_jb_taken,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ret_jb_target,
    input  logic                           trap_vld,
    input  logic                           trap_rdy,
    input  logic                           debug_vld,
    input  logic                           trap_smode,
    input  logic                           indebug_break,
    input  logic                           indebug_exception,
    input  logic                           debug_step_en,
    input  logic                           xret_vld,
    input  logic [1:0]                     xret_type,
    input  logic [ADDR_WIDTH-1:0]          csr_mtvec,
    input  logic [ADDR_WIDTH-1:0]          csr_stvec,
    input  logic [ADDR_WIDTH-1:0]          csr_mepc,
    input  logic [ADDR_WIDTH-1:0]          csr_sepc,
    input  logic [ADDR_WIDTH-1:0]          csr_dpc,
    output logic [ADDR_WIDTH-1:0]          real_pc,
    output logic                           redirect_vld,
    output logic [ADDR_WIDTH-1:0]          redirect_pc,
    input  logic                           redirect_rdy,
    output logic                           pc_lock,
    output logic                           mret_en,
    output logic                           sret_en,
    output logic                           dret_en,
    output logic [$clog2(NUM_CH+1)-1:0]    instret_inc
);

    localparam int CW = $clog2(NUM_CH+1);
    localparam logic [ADDR_WIDTH-1:0] STEP2 = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] STEP4 = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, ENTER, EXIT, JUMP} state_t;

    state_t state, state_d;
    logic [ADDR_WIDTH-1:0] current_pc, seq_pc, next_pc;
    logic [ADDR_WIDTH-1:0] trap_tgt, xret_tgt;
    logic [CW-1:0] cnt;
    logic k_jb, any_ret, debug_hs, trap_hs, accept;
    logic ev_enter, ev_exit, ev_jump, ev_redir;

    // Youngest valid channel overrides older ones (thermometer ret_vld).
    always_comb begin
        seq_pc = current_pc;
        k_jb = 1'b0;
        cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ret_vld[i]) begin
                k_jb = ret_jb_taken[i];
                seq_pc = ret_jb_taken[i]
                    ? ret_jb_target[i*ADDR_WIDTH +: ADDR_WIDTH]
                    : ret_pc[i*ADDR_WIDTH +: ADDR_WIDTH]
                      + ((RVC_EN && ret_rvc[i]) ? STEP2 : STEP4);
                cnt = cnt + CW'(1);
            end
        end
    end

    assign any_ret = |ret_vld;
    assign real_pc = seq_pc;
    assign instret_inc = cnt;

    assign debug_hs = debug_vld && trap_rdy;
    assign trap_hs = trap_vld && trap_rdy;
    assign accept = redirect_vld && redirect_rdy;

    // A single-step trap still wins the cycle, but only updates CSR-side PC.
    assign ev_enter = debug_hs || (trap_hs && !debug_step_en);
    assign ev_exit = !debug_hs && !trap_hs && xret_vld;
    assign ev_jump = !debug_hs && !trap_hs && !xret_vld && any_ret && k_jb;
    assign ev_redir = ev_enter || ev_exit || ev_jump;

    assign trap_tgt = indebug_break ? DBG_LOOP_PC
                    : indebug_exception ? DBG_EXP_PC
                    : trap_smode ? csr_stvec : csr_mtvec;

    always_comb begin
        case (xret_type)
            2'b00:   xret_tgt = csr_sepc;
            2'b10:   xret_tgt = csr_dpc;
            default: xret_tgt = csr_mepc;
        endcase
    end

    // Jump targets are already folded into seq_pc.
    assign next_pc = debug_hs ? DBG_PC
                   : ev_enter ? trap_tgt
                   : ev_exit ? xret_tgt : seq_pc;

    assign mret_en = xret_vld && (xret_type == 2'b01);
    assign sret_en = xret_vld && (xret_type == 2'b00);
    assign dret_en = xret_vld && (xret_type == 2'b10);

    always_comb begin
        state_d = state;
        unique case (1'b1)
            ev_enter: state_d = ENTER;
            ev_exit:  if (state != ENTER) state_d = EXIT;
            ev_jump:  if (state == IDLE) state_d = JUMP;
            default:  if (accept) state_d = IDLE;
        endcase
    end

    assign pc_lock = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            current_pc <= RST_PC;
            redirect_vld <= 1'b0;
            redirect_pc <= '0;
            state <= IDLE;
        end else begin
            current_pc <= next_pc;
            state <= state_d;
            if (ev_redir) begin
                redirect_vld <= 1'b1;
                redirect_pc <= next_pc;
            end else if (accept) begin
                redirect_vld <= 1'b0;
            end
        end
    end

endmodule
